wash_sequencer: RTL and testbench
=================================

// Module: wash_sequencer
// PURPOSE
//   Program controller directly upstream of the wash timer. Walks a wash program step by step.
//   For each step it drives the timer's start, step index and duration.
//   It consumes the timer's per-step completion bits (o_response) and drives the valves, motor and door lock.
//   A new program is started by the panel button.
// PARAMETERS
//   DUR_W      16  width of step duration; matches timer time input
//   CLR_CYC    4   cycles o_timer_clr is held in CLEAR (timer reset is synchronised there)
//   SYNC_STG   2   synchroniser depth on i_response (timer runs on derived slow clock)
// PORTS
//   clk            in   1      system clock
//   rst            in   1      asynchronous reset, active-high
//   i_go           in   1      start button, level; rising edge sampled
//   i_mode         in   2      program: 0 normal, 1 quick, 2 heavy, 3 spin-only; latched at start
//   i_door_closed  in   1      door sensor, 1 = closed
//   i_response     in   4      timer completion bits, sticky, bit n = step n finished
//   o_start        out  1      timer enable (count while high; timer clears count when low)
//   o_step         out  2      current step: 0 wash, 1 rinse, 2 spin, 3 drain
//   o_duration     out  DUR_W  step length in timer ticks
//   o_timer_clr    out  1      drives timer reset (timer reset is active-low; top inverts)
//   o_valve_in     out  1      fill valve
//   o_valve_out    out  1      drain valve
//   o_motor_on     out  1      drum motor
//   o_motor_fast   out  1      spin speed select
//   o_door_lock    out  1      door latch
//   o_busy         out  1      program in progress
//   o_done         out  1      one-cycle pulse at program end
// BEHAVIOUR
//   Reset: state IDLE. All outputs 0. Mode register 0. Step 0.
//   States: IDLE, CLEAR, LOAD, RUN, PAUSE, ADVANCE, DONE.
//   IDLE -> CLEAR: on i_go rise with i_door_closed=1. Latch i_mode. i_go rise with door open is ignored.
//   CLEAR: o_timer_clr=1 for CLR_CYC cycles; clears the timer's sticky response bits. Then go to LOAD.
//   LOAD: step = first enabled step of the mode. o_duration = DUR_TAB[mode][step]. Next cycle go to RUN.
//   RUN: o_start=1, o_door_lock=1, o_busy=1. Actuators per step:
//     wash  -> valve_in + motor_on
//     rinse -> valve_in + motor_on
//     spin  -> valve_out + motor_on + motor_fast
//     drain -> valve_out
//   RUN -> ADVANCE: on synchronised rising edge of i_response[step]. Rising edge only; a bit that is already high is not used.
//   RUN -> PAUSE: on i_door_closed=0. o_start=0, all actuators 0, door_lock=0.
//   PAUSE -> RUN: on door closed AND i_go rise. The step restarts from zero, because the timer clears its count when start drops.
//   ADVANCE: o_start=0 for exactly 1 cycle. Pick next enabled step of the mode.
//     Next step exists -> LOAD.
//     No next step -> DONE.
//   DONE: o_done=1 for 1 cycle, all outputs 0 -> IDLE.
//   Step enable masks (bit n = step n): normal 1111, quick 1011, heavy 1111, spin-only 1100.
//   Step skipping is ascending only. Index wraps are never taken.
//   Duration 0 in the table: that step is skipped as if masked.
//   Simultaneous events in RUN: door-open beats completion edge (PAUSE). The edge is re-armed.
//   i_go while busy: ignored, except in PAUSE.
//   Reset mid-program: immediate return to IDLE. Outputs 0 asynchronously; door unlocks.
//   i_response bits other than the current step are ignored.
//   o_duration is stable from LOAD through RUN and PAUSE.
// STRUCTURE
//   Package wash_pkg:
//     state encoding and step codes (STEP_WASH..STEP_DRAIN)
//     mode codes
//     DUR_TAB[4][4] duration table
//     STEP_MASK[4] step-enable table
//     actuator decode function step -> {valve_in, valve_out, motor_on, motor_fast}
//   Sub-module resp_sync:
//     SYNC_STG-flop synchroniser per i_response bit plus rising-edge detect
//     output: 4-bit one-cycle pulse vector
//   Top: FSM, mode/step registers, CLEAR counter, next-step priority search.
// TESTING
//   1. Mode 0, door closed, i_go pulse; behavioural timer model -> steps 0,1,2,3 in order, correct o_duration each, o_done once, o_busy 0 after.
//   2. Mode 1 -> step sequence 0,1,3 (rinse-free spin skipped per mask 1011); o_step never equals 2.
//   3. Door opened mid-step 1 at tick 5 -> o_start=0, actuators 0, lock 0; close + i_go -> step 1 restarts; completes after full duration.
//   4. i_response[step] forced high on the same cycle as door open -> PAUSE, no advance.
//   5. rst asserted in RUN of step 2 -> all outputs 0 the same cycle; next i_go restarts from CLEAR with o_timer_clr held 4 cycles.
//   6. i_go with door open in IDLE -> stays IDLE, no outputs; stale i_response=4'b1111 at LOAD -> no advance without new edge.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared encodings, program tables and step decode for the wash sequencer.
package wash_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_PAUSE, S_ADVANCE, S_DONE
   } state_t;

   localparam logic [1:0] STEP_WASH  = 2'd0;
   localparam logic [1:0] STEP_RINSE = 2'd1;
   localparam logic [1:0] STEP_SPIN  = 2'd2;
   localparam logic [1:0] STEP_DRAIN = 2'd3;

   localparam logic [1:0] MODE_NORMAL = 2'd0;
   localparam logic [1:0] MODE_QUICK  = 2'd1;
   localparam logic [1:0] MODE_HEAVY  = 2'd2;
   localparam logic [1:0] MODE_SPIN   = 2'd3;

   localparam int TAB_W = 16;

   // [mode][step]; a zero entry drops the step just like a cleared mask bit
   localparam logic [TAB_W-1:0] DUR_TAB [4][4] = '{
      '{16'd8,  16'd6,  16'd5, 16'd4},
      '{16'd4,  16'd3,  16'd0, 16'd2},
      '{16'd12, 16'd10, 16'd6, 16'd0},
      '{16'd0,  16'd0,  16'd7, 16'd3}
   };

   localparam logic [3:0] STEP_MASK [4] = '{4'b1111, 4'b1011, 4'b1111, 4'b1100};

   typedef struct packed {
      logic valve_in;
      logic valve_out;
      logic motor_on;
      logic motor_fast;
   } act_t;

   function automatic act_t act_decode(input logic [1:0] step);
      act_t a;
      a = '0;
      case (step)
         STEP_WASH, STEP_RINSE: begin a.valve_in = 1'b1; a.motor_on = 1'b1; end
         STEP_SPIN:  begin a.valve_out = 1'b1; a.motor_on = 1'b1; a.motor_fast = 1'b1; end
         STEP_DRAIN: a.valve_out = 1'b1;
         default:    a = '0;
      endcase
      return a;
   endfunction

   function automatic logic step_en(input logic [1:0] mode, input logic [1:0] step);
      return STEP_MASK[mode][step] && (DUR_TAB[mode][step] != '0);
   endfunction

   // {found, index} of the lowest enabled step at or above 'from'; from=4 finds nothing
   function automatic logic [2:0] find_step(input logic [1:0] mode, input logic [2:0] from);
      logic [2:0] hit;
      hit = '0;
      for (int i = 3; i >= 0; i--)
         if (i >= int'(from) && step_en(mode, 2'(i)))
            hit = {1'b1, 2'(i)};
      return hit;
   endfunction

endpackage

// File: rtl/resp_sync.sv
// Synchronises the timer's sticky completion bits and turns each rising edge
// into a one-cycle pulse.
module resp_sync #(
   parameter int W        = 4,
   parameter int SYNC_STG = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] pulse
);

   logic [SYNC_STG-1:0][W-1:0] sync_q;
   logic [W-1:0]               prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STG; i++)
            sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STG-1];
      end
   end

   // history is never cleared mid-program, so a bit already high gives no pulse
   assign pulse = sync_q[SYNC_STG-1] & ~prev_q;

endmodule

// File: rtl/wash_sequencer.sv
// Wash program controller: clears the timer, then walks the enabled steps of the
// latched mode, driving timer start/step/duration and the actuators.
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int DUR_W    = 16,
   parameter int CLR_CYC  = 4,
   parameter int SYNC_STG = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_go,
   input  logic [1:0]       i_mode,
   input  logic             i_door_closed,
   input  logic [3:0]       i_response,
   output logic             o_start,
   output logic [1:0]       o_step,
   output logic [DUR_W-1:0] o_duration,
   output logic             o_timer_clr,
   output logic             o_valve_in,
   output logic             o_valve_out,
   output logic             o_motor_on,
   output logic             o_motor_fast,
   output logic             o_door_lock,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CNT_W = $clog2(CLR_CYC + 1);

   state_t           state, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       step_q, step_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [CNT_W-1:0] clr_cnt, clr_cnt_d;
   logic             go_q, go_rise;
   logic [3:0]       resp_pulse;
   logic [2:0]       first_hit, next_hit;
   act_t             act;

   resp_sync #(.W(4), .SYNC_STG(SYNC_STG)) u_resp_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (i_response),
      .pulse (resp_pulse)
   );

   assign go_rise   = i_go & ~go_q;
   assign first_hit = find_step(mode_q, 3'd0);
   assign next_hit  = find_step(mode_q, {1'b0, step_q} + 3'd1);
   assign act       = act_decode(step_q);

   assign o_step     = step_q;
   assign o_duration = dur_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= '0;
         step_q  <= '0;
         dur_q   <= '0;
         clr_cnt <= '0;
         go_q    <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         step_q  <= step_d;
         dur_q   <= dur_d;
         clr_cnt <= clr_cnt_d;
         go_q    <= i_go;
      end
   end

   always_comb begin
      state_d      = state;
      mode_d       = mode_q;
      step_d       = step_q;
      dur_d        = dur_q;
      clr_cnt_d    = clr_cnt;
      o_start      = 1'b0;
      o_timer_clr  = 1'b0;
      o_valve_in   = 1'b0;
      o_valve_out  = 1'b0;
      o_motor_on   = 1'b0;
      o_motor_fast = 1'b0;
      o_door_lock  = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (go_rise && i_door_closed) begin
               mode_d    = i_mode;
               clr_cnt_d = '0;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            o_timer_clr = 1'b1;
            o_busy      = 1'b1;
            if (clr_cnt == CNT_W'(CLR_CYC - 1)) begin
               if (first_hit[2]) begin
                  step_d  = first_hit[1:0];
                  dur_d   = DUR_W'(DUR_TAB[mode_q][first_hit[1:0]]);
                  state_d = S_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               clr_cnt_d = clr_cnt + CNT_W'(1);
            end
         end
         S_LOAD: begin
            o_busy      = 1'b1;
            o_door_lock = 1'b1;
            state_d     = S_RUN;
         end
         S_RUN: begin
            o_start      = 1'b1;
            o_door_lock  = 1'b1;
            o_busy       = 1'b1;
            o_valve_in   = act.valve_in;
            o_valve_out  = act.valve_out;
            o_motor_on   = act.motor_on;
            o_motor_fast = act.motor_fast;
            // door wins; a completion pulse seen together with it is dropped
            if (!i_door_closed)             state_d = S_PAUSE;
            else if (resp_pulse[step_q])    state_d = S_ADVANCE;
         end
         S_PAUSE: begin
            o_busy = 1'b1;
            if (i_door_closed && go_rise) state_d = S_RUN;
         end
         S_ADVANCE: begin
            o_busy      = 1'b1;
            o_door_lock = 1'b1;
            if (next_hit[2]) begin
               step_d  = next_hit[1:0];
               dur_d   = DUR_W'(DUR_TAB[mode_q][next_hit[1:0]]);
               state_d = S_LOAD;
            end else begin
               step_d  = '0;
               dur_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: program-level reference model checked every cycle,
// a simple timer model closing the loop, and directed scenarios.
module tb_wash_sequencer;

   localparam int DUR_W    = 16;
   localparam int CLR_CYC  = 4;
   localparam int SYNC_STG = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             i_go, i_door_closed;
   logic [1:0]       i_mode;
   logic [3:0]       i_response, resp_force;
   logic             o_start, o_timer_clr, o_valve_in, o_valve_out;
   logic             o_motor_on, o_motor_fast, o_door_lock, o_busy, o_done;
   logic [1:0]       o_step;
   logic [DUR_W-1:0] o_duration;

   always #5 clk = ~clk;

   wash_sequencer #(.DUR_W(DUR_W), .CLR_CYC(CLR_CYC), .SYNC_STG(SYNC_STG)) dut (
      .clk(clk), .rst(rst), .i_go(i_go), .i_mode(i_mode), .i_door_closed(i_door_closed),
      .i_response(i_response), .o_start(o_start), .o_step(o_step), .o_duration(o_duration),
      .o_timer_clr(o_timer_clr), .o_valve_in(o_valve_in), .o_valve_out(o_valve_out),
      .o_motor_on(o_motor_on), .o_motor_fast(o_motor_fast), .o_door_lock(o_door_lock),
      .o_busy(o_busy), .o_done(o_done)
   );

   logic [26:0] dut_out;
   assign dut_out = {o_start, o_step, o_duration, o_timer_clr, o_valve_in, o_valve_out,
                     o_motor_on, o_motor_fast, o_door_lock, o_busy, o_done};

   // program tables as the product defines them
   int unsigned tb_dur [4][4] = '{'{8,6,5,4}, '{4,3,0,2}, '{12,10,6,0}, '{0,0,7,3}};
   logic [3:0]  tb_mask [4]   = '{4'b1111, 4'b1011, 4'b1111, 4'b1100};

   // timer: counts while start is high, latches bit[step] when count hits duration
   logic [3:0] tbits = '0;
   int         tcnt  = 0;
   always @(negedge clk) begin
      if (o_timer_clr) begin tbits = '0; tcnt = 0; end
      else if (o_start) begin
         tcnt++;
         if (tcnt == int'(o_duration)) tbits[o_step] = 1'b1;
      end else tcnt = 0;
   end
   assign i_response = tbits | resp_force;

   // reference model: ordered list of steps the program will visit plus a phase
   typedef enum {M_IDLE, M_CLR, M_LOAD, M_RUN, M_HOLD, M_NEXT, M_FIN} mph_t;
   mph_t       ph = M_IDLE;
   int         plist[$];
   int         ppos = 0, clr_left = 0;
   logic [1:0] mmode = '0;
   logic       mgo_prev = 1'b0;
   logic [3:0] hist[$];

   always @(posedge clk or posedge rst) begin : model
      logic [3:0] pulse;
      logic       rise;
      if (rst) begin
         ph = M_IDLE; ppos = 0; mgo_prev = 1'b0; mmode = '0;
         hist.delete();
         for (int i = 0; i <= SYNC_STG; i++) hist.push_back(4'b0);
      end else begin
         // completion seen SYNC_STG cycles late, rising edges only
         pulse = hist[SYNC_STG-1] & ~hist[SYNC_STG];
         hist.push_front(i_response);
         void'(hist.pop_back());
         rise = i_go & ~mgo_prev;
         mgo_prev = i_go;
         case (ph)
            M_IDLE: if (rise && i_door_closed) begin
               mmode = i_mode;
               plist.delete();
               for (int s = 0; s < 4; s++)
                  if (tb_mask[i_mode][s] && tb_dur[i_mode][s] != 0) plist.push_back(s);
               clr_left = CLR_CYC;
               ph = M_CLR;
            end
            M_CLR: begin
               clr_left--;
               if (clr_left == 0) begin ppos = 0; ph = (plist.size() > 0) ? M_LOAD : M_FIN; end
            end
            M_LOAD: ph = M_RUN;
            M_RUN: if (!i_door_closed) ph = M_HOLD;
                   else if (pulse[plist[ppos]]) ph = M_NEXT;
            M_HOLD: if (i_door_closed && rise) ph = M_RUN;
            M_NEXT: if (ppos + 1 < plist.size()) begin ppos++; ph = M_LOAD; end
                    else ph = M_FIN;
            default: ph = M_IDLE;
         endcase
      end
   end

   function automatic logic [26:0] model_out();
      logic       on, run;
      int         s;
      logic [3:0] act;
      on  = ph inside {M_LOAD, M_RUN, M_HOLD, M_NEXT};
      run = (ph == M_RUN);
      s   = on ? plist[ppos] : 0;
      act = !run ? 4'b0000 : (s < 2) ? 4'b1010 : (s == 2) ? 4'b0111 : 4'b0100;
      return {run, 2'(s), on ? 16'(tb_dur[mmode][s]) : 16'd0, ph == M_CLR, act,
              ph inside {M_LOAD, M_RUN, M_NEXT}, ph inside {M_CLR, M_LOAD, M_RUN, M_HOLD, M_NEXT},
              ph == M_FIN};
   endfunction

   // record each timer run: step, duration, cycles with start high
   int   steps_q[$], durs_q[$], lens_q[$];
   int   runlen = 0, done_cnt = 0, step2_cyc = 0;
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (o_start && !prev_start) begin
         steps_q.push_back(int'(o_step)); durs_q.push_back(int'(o_duration)); runlen = 1;
      end else if (o_start) runlen++;
      if (!o_start && prev_start) lens_q.push_back(runlen);
      if (o_done) done_cnt++;
      if (o_step == 2'd2) step2_cyc++;
      prev_start = o_start;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_go();
      i_go = 1'b1; tick(1); i_go = 1'b0; tick(1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (o_done !== 1'b1 && n < budget) begin tick(1); n++; end
      chk({name, "_done_seen"}, o_done, 1);
      tick(1);
   endtask

   task automatic wait_run(input int s, input int budget);
      int n = 0;
      while (!(o_start === 1'b1 && int'(o_step) == s) && n < budget) begin tick(1); n++; end
      chk($sformatf("run_step%0d_reached", s), o_start === 1'b1 && int'(o_step) == s, 1);
   endtask

   task automatic chk_runs(input string name, input int b, input int n,
                           input int es[5], input int ed[5], input int el[5]);
      chk({name, "_runs"}, steps_q.size() - b, n);
      if (steps_q.size() - b == n && lens_q.size() - b == n)
         for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_step%0d", name, k), steps_q[b+k], es[k]);
            chk($sformatf("%s_dur%0d", name, k),  durs_q[b+k],  ed[k]);
            chk($sformatf("%s_len%0d", name, k),  lens_q[b+k],  el[k]);
         end
   endtask

   // per-mode expected runs; a run lasts duration + SYNC_STG cycles
   int mode_n [4]     = '{4, 3, 3, 2};
   int mode_s [4][5]  = '{'{0,1,2,3,0}, '{0,1,3,0,0}, '{0,1,2,0,0}, '{2,3,0,0,0}};
   int mode_d [4][5]  = '{'{8,6,5,4,0}, '{4,3,2,0,0}, '{12,10,6,0,0}, '{7,3,0,0,0}};
   int mode_l [4][5]  = '{'{10,8,7,6,0}, '{6,5,4,0,0}, '{14,12,8,0,0}, '{9,5,0,0,0}};
   int m0_d   [5]     = '{8,6,6,5,4};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b, d0, s2, n;
      int ps[5], pl[5];
      fork
         forever begin
            @(negedge clk);
            checks++;
            if (dut_out !== model_out()) begin
               errors++;
               $display("FAIL outputs t=%0t got=%h expected=%h", $time, dut_out, model_out());
            end
         end
      join_none

      i_go = 1'b0; i_door_closed = 1'b1; i_mode = 2'd0; resp_force = '0;
      #2 rst = 1'b1;
      tick(3);
      chk("reset_outputs", dut_out, 0);
      rst = 1'b0;
      tick(2);

      // every mode end to end
      for (int m = 0; m < 4; m++) begin
         b = steps_q.size(); d0 = done_cnt; s2 = step2_cyc;
         i_mode = 2'(m);
         press_go();
         wait_done($sformatf("mode%0d", m), 200);
         chk($sformatf("mode%0d_done_once", m), done_cnt - d0, 1);
         chk($sformatf("mode%0d_busy_after", m), o_busy, 0);
         chk_runs($sformatf("mode%0d", m), b, mode_n[m], mode_s[m], mode_d[m], mode_l[m]);
         if (m == 1) chk("quick_no_spin", step2_cyc - s2, 0);
         tick(2);
      end

      // door opens during rinse, then restart
      b = steps_q.size(); i_mode = 2'd0;
      press_go();
      wait_run(1, 100);
      n = 0;
      while (tcnt < 4 && n < 50) begin tick(1); n++; end
      i_door_closed = 1'b0;
      tick(1);
      chk("pause_start", o_start, 0);
      chk("pause_lock", o_door_lock, 0);
      chk("pause_actuators", {o_valve_in, o_valve_out, o_motor_on, o_motor_fast}, 0);
      chk("pause_step", o_step, 1);
      tick(3);
      i_door_closed = 1'b1;
      tick(1);
      press_go();
      wait_done("door_pause", 200);
      ps = '{0,1,1,2,3}; pl = '{10,5,8,7,6};
      chk_runs("door_pause", b, 5, ps, m0_d, pl);
      tick(2);

      // completion edge on the same cycle as door open
      b = steps_q.size();
      press_go();
      wait_run(0, 100);
      tick(2);
      resp_force = 4'b0001;
      tick(2);
      i_door_closed = 1'b0;
      tick(1);
      chk("collide_start", o_start, 0);
      chk("collide_step", o_step, 0);
      chk("collide_busy", o_busy, 1);
      tick(3);
      resp_force = '0; i_door_closed = 1'b1;
      tick(1);
      press_go();
      wait_done("collide", 200);
      ps = '{0,0,1,2,3}; pl = '{5,10,8,7,6};
      chk_runs("collide", b, 5, ps, '{8,8,6,5,4}, pl);
      tick(2);

      // reset during spin, then a clean restart
      press_go();
      wait_run(2, 200);
      tick(1);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", dut_out, 0);
      @(posedge clk); #1 rst = 1'b0;
      tick(2);
      i_go = 1'b1; tick(1); i_go = 1'b0;
      n = 0;
      while (o_timer_clr === 1'b1 && n < 20) begin n++; tick(1); end
      chk("clear_cycles", n, CLR_CYC);
      wait_done("after_reset", 200);
      tick(2);

      // go with door open is ignored; stale response bits never advance
      i_door_closed = 1'b0;
      press_go();
      tick(3);
      chk("door_open_go_busy", o_busy, 0);
      chk("door_open_go_outputs", dut_out, 0);
      i_door_closed = 1'b1; resp_force = 4'b1111;
      tick(5);
      press_go();
      wait_run(0, 50);
      tick(30);
      chk("stale_still_running", o_start, 1);
      chk("stale_still_step0", o_step, 0);
      #2 rst = 1'b1;
      tick(1);
      rst = 1'b0; resp_force = '0;
      tick(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
